// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and
// shared mult/div unit hazards, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_Ra,
  input  logic [4:0]       id_Rb,
  input  logic             id_useRb,
  input  logic             id_isMD,
  input  logic             id_isDiv,
  input  logic             id_readsHiLo,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_Rw,
  input  logic             ex_PCSrc,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  // state  | meaning
  // IDLE   | mult/div unit free, an MD op in ID may start
  // MD_RUN | op in flight; md_cnt_q counts remaining cycles down to 0
  typedef enum logic {IDLE, MD_RUN} state_t;

  localparam logic [5:0] MUL_INIT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_INIT = 6'(DIV_LAT - 1);

  state_t           state_q, state_d;
  logic [5:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lu, md_last, mdh, stall, md_accept;

  always_comb begin
    lu = ex_MemRead && (ex_Rw != 5'd0) &&
         ((ex_Rw == id_Ra) || (id_useRb && (ex_Rw == id_Rb)));
    // In the final cycle HI/LO is written and forwarded, so consumers may proceed.
    md_last   = (state_q == MD_RUN) && (md_cnt_q == 6'd0);
    mdh       = (state_q == MD_RUN) && (md_cnt_q != 6'd0) && (id_isMD || id_readsHiLo);
    stall     = (lu || mdh) && !ex_PCSrc;
    md_accept = ((state_q == IDLE) || md_last) && id_isMD && !lu && !ex_PCSrc;
  end

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (md_accept) begin
      state_d  = MD_RUN;
      md_cnt_d = id_isDiv ? DIV_INIT : MUL_INIT;
    end else if (state_q == MD_RUN) begin
      if (md_cnt_q == 6'd0) begin
        state_d = IDLE;
      end else begin
        md_cnt_d = md_cnt_q - 6'd1;
      end
    end
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      md_cnt_q    <= 6'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset is synchronous, so stale state must be masked while rst is held.
  always_comb begin
    pc_stall   = stall && !rst;
    ifid_stall = stall && !rst;
    ifid_flush = ex_PCSrc && !rst;
    idex_flush = (ex_PCSrc || stall) && !rst;
    md_start   = md_accept && !rst;
    md_busy    = (state_q == MD_RUN) && !rst;
    stall_cnt  = rst ? '0 : stall_cnt_q;
  end

endmodule
